toggle_hs_rx: RTL and testbench
===============================

// Module: toggle_hs_rx
// PURPOSE
//  Responder end of the toggle-encoded request/acknowledge link: the initiator flips req_tog
//  once per word, holding req_data stable; this block detects each flip, buffers the word,
//  and flips ack_tog to return the handshake. Buffered words leave on a valid/ready stream
//  port. Sits between a toggle-driven producer and any stream consumer in the same clock domain.
// PARAMETERS
//  DW     8   data width of req_data / out_data
//  DEPTH  4   buffer entries; power of two, >= 2
//  AW     2   log2(DEPTH); must match DEPTH
// PORTS
//  clk       input   1   rising-edge clock; the only clock
//  rst       input   1   synchronous, active-high reset
//  req_tog   input   1   request toggle; each level change = one new word
//  req_data  input   DW  word; stable from req_tog flip until matching ack_tog flip
//  ack_tog   output  1   acknowledge toggle; flips once per accepted word
//  out_data  output  DW  head-of-buffer word
//  out_valid output  1   buffer not empty
//  out_ready input   1   consumer accepts out_data when out_valid && out_ready
//  err       output  1   sticky protocol error (request withdrawn before ack)
// BEHAVIOUR
//  - Reset: ack_tog=0, req_seen=0, count=0, out_valid=0, err=0, pending=0. Initiator resets req_tog=0.
//  - req_s = req_tog (or synchronised copy, see CONFIGURATION). edge = (req_s != req_seen).
//  - Accept: edge && !full (count before any pop) -> at next clk: write req_data at wr_ptr,
//    wr_ptr++, req_seen<=req_s, ack_tog<=~ack_tog. One word per edge, never more.
//  - Stall: edge && full -> no write, no ack; pending<=1; edge re-evaluated every cycle.
//  - Withdraw: pending==1 && !edge -> err<=1 (sticky until rst), pending<=0, nothing written.
//  - Pop: out_valid && out_ready -> rd_ptr++ at clk. out_data = mem[rd_ptr] (registered storage,
//    combinational read).
//  - Push+pop same cycle (not full): both occur, count unchanged. Push while full is never taken
//    even if a pop happens that cycle; word accepted the cycle after (1-cycle bubble, by design).
//  - Latency (no sync): req_tog flip sampled at edge k -> ack_tog flip and out_valid=1 after edge k.
//  - Pointers wrap modulo DEPTH; count is AW+1 bits, full = (count==DEPTH), empty = (count==0).
//  - Reset mid-transfer: buffer flushed, pending ack lost; both link ends must be reset together.
// CONFIGURATION
//  TOGGLE_HS_RX_SYNC_EN defined: req_tog passes a 2-flop synchroniser (reset 0) before edge
//   detect; latency +2 cycles; req_data captured when synchronised edge seen (initiator holds it).
//  Not defined: req_tog used directly; initiator must be synchronous to clk.
// STRUCTURE
//  - Shared package toggle_hs_pkg: default DW/DEPTH constants, protocol-error code constant.
//  - One sub-module: sync_fifo (DW, DEPTH, AW; wr_en/wr_data/rd_en/rd_data/full/empty/count),
//    reusable elsewhere. Top keeps edge detect, req_seen, ack_tog, pending/err logic.
// TESTING
//  1. rst 2 cycles -> ack_tog=0, out_valid=0, err=0; req_tog held 0 -> no activity.
//  2. req_data=8'hA5, req_tog 0->1, out_ready=1 -> ack_tog 0->1 next edge, out_data=A5 one
//     cycle, then out_valid=0.
//  3. out_ready=0, send 5 words 01..05 waiting for ack each -> 4 acks, 5th stalls; raise
//     out_ready -> 5th acked one cycle after first pop; drain order 01,02,03,04,05.
//  4. Buffer full, pending word, then req_tog flipped back before ack -> err=1, count stays 4,
//     no ack flip; err holds through further traffic until rst.
//  5. 2 words buffered, assert rst mid-stream -> out_valid=0, count=0, ack_tog=0 next cycle.
//  6. With TOGGLE_HS_RX_SYNC_EN: case 2 -> ack_tog flip delayed exactly 2 extra cycles.

Source files
------------

// File: rtl/toggle_hs_rx_pkg.sv
// Shared constants and types for the toggle-handshake responder and its buffer.
package toggle_hs_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned AW_DEF    = 2;

  typedef enum logic {
    LINK_IDLE,
    LINK_STALL
  } link_state_e;

  typedef enum logic {
    ERR_NONE,
    ERR_WITHDRAWN
  } err_code_e;

  localparam err_code_e PROTO_ERR = ERR_WITHDRAWN;

endpackage

// File: rtl/toggle_hs_rx_if.sv
// Toggle request/acknowledge link plus valid/ready output stream.
import toggle_hs_pkg::*;

interface toggle_hs_rx_if #(
  parameter int unsigned DW = DW_DEF
) ();
  logic          req_tog;
  logic [DW-1:0] req_data;
  logic          ack_tog;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          err;

  modport slave (
    input  req_tog, req_data, out_ready,
    output ack_tog, out_data, out_valid, err
  );

  modport master (
    output req_tog, req_data, out_ready,
    input  ack_tog, out_data, out_valid, err
  );
endinterface

// File: rtl/toggle_hs_rx_sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
import toggle_hs_pkg::*;

module sync_fifo #(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    mem_d    = mem_q;
    if (do_wr) mem_d[wr_ptr_q] = wr_data;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/toggle_hs_rx.sv
// Responder end of a toggle request/ack link, buffering words onto a valid/ready stream.
// Define TOGGLE_HS_RX_SYNC_EN to pass req_tog through a 2-flop synchroniser first.
import toggle_hs_pkg::*;

module toggle_hs_rx #(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input logic          clk,
  input logic          rst,
  toggle_hs_rx_if.slave bus
);
  logic        req_s, req_edge;
  logic        req_seen_q, req_seen_d;
  logic        ack_q, ack_d;
  link_state_e link_q, link_d;
  err_code_e   err_q, err_d;
  logic        wr_en, rd_en;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

`ifdef TOGGLE_HS_RX_SYNC_EN
  logic sync1_q, sync1_d, sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.req_tog;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = bus.req_tog;
`endif

  assign req_edge = (req_s != req_seen_q);

  // Full is judged before any same-cycle pop, so a stalled word waits one extra cycle.
  always_comb begin
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    link_d     = LINK_IDLE;
    err_d      = err_q;
    wr_en      = 1'b0;
    if (req_edge && !fifo_full) begin
      wr_en      = 1'b1;
      req_seen_d = req_s;
      ack_d      = ~ack_q;
    end else if (req_edge) begin
      link_d = LINK_STALL;
    end
    if (link_q == LINK_STALL && !req_edge) err_d = PROTO_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      link_q     <= LINK_IDLE;
      err_q      <= ERR_NONE;
    end else begin
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      link_q     <= link_d;
      err_q      <= err_d;
    end
  end

  assign rd_en = !fifo_empty && bus.out_ready;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.req_data),
    .rd_en   (rd_en),
    .rd_data (bus.out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);
  assign bus.ack_tog   = ack_q;
  assign bus.err       = (err_q == PROTO_ERR);
endmodule

// File: tb/tb_toggle_hs_rx.sv
// Bench for toggle_hs_rx: queue-based reference model checked every cycle plus directed literal checks.
module tb_toggle_hs_rx;
  localparam int unsigned DEPTH = 4;
`ifdef TOGGLE_HS_RX_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  toggle_hs_rx_if #(.DW(8)) bus ();

  toggle_hs_rx #(.DW(8), .DEPTH(DEPTH), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: word queue, ack parity, last seen request level, stall/err flags.
  logic [7:0] mq[$];
  logic m_ack = 1'b0, m_seen = 1'b0, m_pend = 1'b0, m_err = 1'b0;
  logic m_s1 = 1'b0, m_s2 = 1'b0;

  // Inputs change just after posedge, so at negedge they hold what the next posedge samples.
  always @(negedge clk) begin
    logic rs, e, is_full;
    if (chk_en) begin
      check("ack_tog", 32'(bus.ack_tog), 32'(m_ack));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) check("out_data", 32'(bus.out_data), 32'(mq[0]));
      check("err", 32'(bus.err), 32'(m_err));
    end
    if (rst) begin
      mq.delete();
      m_ack = 1'b0; m_seen = 1'b0; m_pend = 1'b0; m_err = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
`ifdef TOGGLE_HS_RX_SYNC_EN
      rs = m_s2; m_s2 = m_s1; m_s1 = bus.req_tog;
`else
      rs = bus.req_tog;
`endif
      e = (rs != m_seen);
      is_full = (mq.size() == DEPTH);
      if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
      if (e && !is_full) begin
        mq.push_back(bus.req_data);
        m_seen = rs;
        m_ack = ~m_ack;
      end
      if (m_pend && !e) m_err = 1'b1;
      m_pend = e && is_full;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int unsigned max, output bit got, output int unsigned cyc);
    logic prev;
    prev = bus.ack_tog;
    bus.req_data = d;
    bus.req_tog = ~bus.req_tog;
    got = 1'b0;
    cyc = 0;
    for (int unsigned i = 0; i < max; i++) begin
      step();
      cyc++;
      if (bus.ack_tog != prev) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit          got;
    int unsigned cyc;
    logic        prev_ack, exp_ack;
    logic [7:0]  rx[$];

    bus.req_tog = 1'b0;
    bus.req_data = '0;
    bus.out_ready = 1'b0;

    // Reset and idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_ack", 32'(bus.ack_tog), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (3) step();
    check("idle_ack", 32'(bus.ack_tog), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    // Single word with consumer ready
    bus.out_ready = 1'b1;
    send(8'hA5, 8, got, cyc);
    check("single_acked", 32'(got), 32'd1);
    check("single_latency", cyc, LAT);
    check("single_ack", 32'(bus.ack_tog), 32'd1);
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data", 32'(bus.out_data), 32'hA5);
    step();
    check("single_drained", 32'(bus.out_valid), 32'd0);

    // Fill while consumer stalled; fifth word waits for a pop
    bus.out_ready = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      send(8'(i), 8, got, cyc);
      check("fill_acked", 32'(got), 32'd1);
    end
    send(8'h05, 6, got, cyc);
    check("fifth_stalls", 32'(got), 32'd0);
    prev_ack = bus.ack_tog;
    exp_ack = ~prev_ack;
    bus.out_ready = 1'b1;
    rx.delete();
    rx.push_back(bus.out_data);
    step();
    check("bubble_no_ack", 32'(bus.ack_tog), 32'(prev_ack));
    if (bus.out_valid) rx.push_back(bus.out_data);
    step();
    check("bubble_ack", 32'(bus.ack_tog), 32'(exp_ack));
    for (int unsigned i = 0; i < 10; i++) begin
      if (bus.out_valid) rx.push_back(bus.out_data);
      step();
    end
    check("drain_count", rx.size(), 32'd5);
    for (int unsigned i = 0; i < 5 && i < rx.size(); i++)
      check("drain_order", 32'(rx[i]), i + 1);

    // Withdrawn request while full sets sticky err
    bus.out_ready = 1'b0;
    for (int unsigned i = 6; i <= 9; i++) begin
      send(8'(i), 8, got, cyc);
      check("refill_acked", 32'(got), 32'd1);
    end
    send(8'h0A, 4, got, cyc);
    check("pend_stalls", 32'(got), 32'd0);
    prev_ack = bus.ack_tog;
    bus.req_tog = ~bus.req_tog;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      if (bus.err) break;
    end
    check("withdraw_err", 32'(bus.err), 32'd1);
    check("withdraw_no_ack", 32'(bus.ack_tog), 32'(prev_ack));
    bus.out_ready = 1'b1;
    rx.delete();
    for (int unsigned i = 0; i < 10; i++) begin
      if (bus.out_valid) rx.push_back(bus.out_data);
      step();
    end
    check("withdraw_count", rx.size(), 32'd4);
    for (int unsigned i = 0; i < 4 && i < rx.size(); i++)
      check("withdraw_order", 32'(rx[i]), i + 6);
    send(8'h0B, 8, got, cyc);
    check("after_err_acked", 32'(got), 32'd1);
    step();
    check("err_sticky", 32'(bus.err), 32'd1);

    // Reset mid-stream with two buffered words
    bus.out_ready = 1'b0;
    send(8'h11, 8, got, cyc);
    send(8'h22, 8, got, cyc);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    bus.req_tog = 1'b0;
    step();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ack", 32'(bus.ack_tog), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    step();
    bus.out_ready = 1'b1;
    send(8'h33, 8, got, cyc);
    check("post_rst_acked", 32'(got), 32'd1);
    check("post_rst_data", 32'(bus.out_data), 32'h33);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
